// File: rtl/ixu_pkg.sv
// ixu_pkg: shared constants, scoreboard entry and issue FSM state types for the IXU issue path.
// Rev 1.0
`default_nettype none

package ixu_pkg;

  localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
  localparam logic [6:0]  OPC_ITYPE = 7'b0010011;
  localparam logic [31:0] INST_NOP  = 32'h0;
  localparam int          NUM_LANES = 2;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ISS_EMPTY = 2'd0,
    ISS_HELD  = 2'd1,
    ISS_SPLIT = 2'd2
  } iss_state_t;

  function automatic logic lane_legal(input logic [31:0] inst);
    return (inst == INST_NOP) || (inst[6:0] == OPC_RTYPE) || (inst[6:0] == OPC_ITYPE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ixu_scoreboard.sv
// ixu_scoreboard: per-lane WB_LAT-deep shift register of pending writes, with busy lookup for 4 sources.
// Rev 1.0
`default_nettype none

module ixu_scoreboard
  import ixu_pkg::*;
#(
  parameter int WB_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] load_vld,
  input  logic [9:0]           load_rd,
  input  logic [19:0]          src,
  output logic [3:0]           busy
);

  sb_entry_t stage [NUM_LANES][WB_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < NUM_LANES; l++)
        for (int k = 0; k < WB_LAT; k++)
          stage[l][k] <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        stage[l][0] <= {load_vld[l], load_rd[l*5 +: 5]};
        for (int k = 1; k < WB_LAT; k++)
          stage[l][k] <= stage[l][k-1];
      end
    end
  end

  // x0 is hardwired zero, so it never waits on a write
  always_comb begin
    busy = '0;
    for (int s = 0; s < 4; s++)
      for (int l = 0; l < NUM_LANES; l++)
        for (int k = 0; k < WB_LAT; k++)
          if (src[s*5 +: 5] != 5'd0 && stage[l][k].vld && stage[l][k].rd == src[s*5 +: 5])
            busy[s] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/ixu_issue_ctrl.sv
// ixu_issue_ctrl: holds one 2-lane bundle, checks RAW hazards against the scoreboard,
// splits intra-bundle dependencies and drives registered per-lane issue.  Rev 1.0
`default_nettype none

module ixu_issue_ctrl
  import ixu_pkg::*;
#(
  parameter int WB_LAT  = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bndl_valid,
  output logic               bndl_ready,
  input  logic [63:0]        bndl_inst,
  input  logic               flush,
  output logic [1:0]         iss_valid,
  output logic [63:0]        iss_inst,
  output logic               illegal,
  output logic [STALL_W-1:0] stall_cnt
);

  iss_state_t state;
  logic [63:0] hold;

  logic [NUM_LANES-1:0] wr_rd, use_rs1, use_rs2, lane_ok;
  logic [4:0] rd  [NUM_LANES];
  logic [4:0] rs1 [NUM_LANES];
  logic [4:0] rs2 [NUM_LANES];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_dec
    logic is_r, is_i;
    assign is_r       = hold[l*32 +: 7] == OPC_RTYPE;
    assign is_i       = hold[l*32 +: 7] == OPC_ITYPE;
    assign rd[l]      = hold[l*32+7  +: 5];
    assign rs1[l]     = hold[l*32+15 +: 5];
    assign rs2[l]     = hold[l*32+20 +: 5];
    assign use_rs1[l] = is_r | is_i;
    assign use_rs2[l] = is_r;
    assign wr_rd[l]   = (is_r | is_i) && (rd[l] != 5'd0);
    assign lane_ok[l] = lane_legal(bndl_inst[l*32 +: 32]);
  end

  logic conflict;
  assign conflict = (wr_rd[0] && ((use_rs1[1] && rs1[1] == rd[0]) ||
                                  (use_rs2[1] && rs2[1] == rd[0]))) ||
                    (wr_rd[0] && wr_rd[1] && rd[0] == rd[1]);

  logic [19:0] src;
  logic [3:0]  busy;
  logic        free0, free1;
  assign src = {use_rs2[1] ? rs2[1] : 5'd0, use_rs1[1] ? rs1[1] : 5'd0,
                use_rs2[0] ? rs2[0] : 5'd0, use_rs1[0] ? rs1[0] : 5'd0};
  assign free0 = ~|busy[1:0];
  assign free1 = ~|busy[3:2];

  logic issue0_only, issue_both, issue1_only, full_issue, accept;
  assign issue0_only = (state == ISS_HELD)  && conflict  && free0 && !flush;
  assign issue_both  = (state == ISS_HELD)  && !conflict && free0 && free1 && !flush;
  assign issue1_only = (state == ISS_SPLIT) && free1 && !flush;
  assign full_issue  = issue_both | issue1_only;
  assign bndl_ready  = !rst && !flush && ((state == ISS_EMPTY) || full_issue);
  assign accept      = bndl_valid && bndl_ready;

  logic [NUM_LANES-1:0] load_vld;
  assign load_vld = {full_issue && wr_rd[1], (issue_both | issue0_only) && wr_rd[0]};

  ixu_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .load_vld (load_vld),
    .load_rd  ({rd[1], rd[0]}),
    .src      (src),
    .busy     (busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ISS_EMPTY;
      hold      <= '0;
      iss_valid <= '0;
      iss_inst  <= '0;
      illegal   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      iss_valid <= '0;
      iss_inst  <= '0;
      illegal   <= 1'b0;

      // illegal lanes are neutralised here so the rest of the pipe only sees NOPs
      if (accept) begin
        hold    <= {lane_ok[1] ? bndl_inst[63:32] : INST_NOP,
                    lane_ok[0] ? bndl_inst[31:0]  : INST_NOP};
        illegal <= ~&lane_ok;
      end

      if (issue_both) begin
        iss_valid <= {hold[63:32] != INST_NOP, hold[31:0] != INST_NOP};
        iss_inst  <= hold;
      end else if (issue0_only) begin
        iss_valid <= {1'b0, hold[31:0] != INST_NOP};
        iss_inst  <= {INST_NOP, hold[31:0]};
      end else if (issue1_only) begin
        iss_valid <= {hold[63:32] != INST_NOP, 1'b0};
        iss_inst  <= {hold[63:32], INST_NOP};
      end

      if (state != ISS_EMPTY && !flush && !(issue_both | issue0_only | issue1_only) &&
          stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        state <= ISS_EMPTY;
      end else begin
        case (state)
          ISS_EMPTY: if (accept) state <= ISS_HELD;
          ISS_HELD: begin
            if (issue0_only)     state <= ISS_SPLIT;
            else if (issue_both) state <= accept ? ISS_HELD : ISS_EMPTY;
          end
          ISS_SPLIT: if (issue1_only) state <= accept ? ISS_HELD : ISS_EMPTY;
          default: state <= ISS_EMPTY;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ixu_issue_ctrl.sv
// tb_ixu_issue_ctrl: directed vector table plus hand-written multi-cycle sequences for ixu_issue_ctrl.
// Rev 1.0
`default_nettype none

module tb_ixu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, bndl_valid, bndl_ready, flush, illegal;
  logic [63:0] bndl_inst, iss_inst;
  logic [1:0]  iss_valid;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ixu_issue_ctrl #(.WB_LAT(2), .STALL_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bndl_valid (bndl_valid),
    .bndl_ready (bndl_ready),
    .bndl_inst  (bndl_inst),
    .flush      (flush),
    .iss_valid  (iss_valid),
    .iss_inst   (iss_inst),
    .illegal    (illegal),
    .stall_cnt  (stall_cnt)
  );

  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                     input logic [2:0] f3, input logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] it(input logic [11:0] imm, input logic [4:0] r1,
                                     input logic [2:0] f3, input logic [4:0] d);
    return {imm, r1, f3, d, 7'b0010011};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; bndl_valid = 1'b0; flush = 1'b0; bndl_inst = '0;
    repeat (n) step();
    rst = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [63:0] inst;
    logic        ill;
    logic [1:0]  v1;
    logic [63:0] i1;
    int          d2;
    logic [1:0]  v2;
    logic [63:0] i2;
    logic [15:0] stall;
  } vec_t;

  vec_t vecs [9];

  logic [31:0] A, ADDI4, XOR6, OR9, SUB1, ADDI2_1, ADD0, ADD3, ADD6, ADDI5, ADDI8, ADD7, ADDI3;

  initial begin
    A       = rt(7'd0, 5'd3, 5'd2, 3'd0, 5'd1);        // add  x1,x2,x3
    ADDI4   = it(12'd7, 5'd5, 3'd0, 5'd4);             // addi x4,x5,7
    XOR6    = rt(7'd0, 5'd8, 5'd7, 3'd4, 5'd6);        // xor  x6,x7,x8
    OR9     = rt(7'd0, 5'd11, 5'd10, 3'd6, 5'd9);      // or   x9,x10,x11
    SUB1    = rt(7'b0100000, 5'd5, 5'd4, 3'd0, 5'd1);  // sub  x1,x4,x5
    ADDI2_1 = it(12'd1, 5'd1, 3'd0, 5'd2);             // addi x2,x1,1
    ADD0    = rt(7'd0, 5'd2, 5'd1, 3'd0, 5'd0);        // add  x0,x1,x2
    ADD3    = rt(7'd0, 5'd0, 5'd0, 3'd0, 5'd3);        // add  x3,x0,x0
    ADD6    = rt(7'd0, 5'd5, 5'd0, 3'd0, 5'd6);        // add  x6,x0,x5
    ADDI5   = it(12'd1, 5'd0, 3'd0, 5'd5);             // addi x5,x0,1
    ADDI8   = it(12'd7, 5'd1, 3'd0, 5'd8);             // addi x8,x1,7 (imm[4:0] aliases rs2=x7)
    ADD7    = rt(7'd0, 5'd2, 5'd1, 3'd0, 5'd7);        // add  x7,x1,x2
    ADDI3   = it(12'd2, 5'd1, 3'd0, 5'd3);             // addi x3,x1,2

    vecs[0] = '{{ADDI4, A},        1'b0, 2'b11, {ADDI4, A},        1, 2'b00, 64'h0,            16'd0};
    vecs[1] = '{{XOR6, 32'h0},     1'b0, 2'b10, {XOR6, 32'h0},     1, 2'b00, 64'h0,            16'd0};
    vecs[2] = '{{SUB1, A},         1'b0, 2'b01, {32'h0, A},        1, 2'b10, {SUB1, 32'h0},    16'd0};
    vecs[3] = '{{ADDI2_1, A},      1'b0, 2'b01, {32'h0, A},        3, 2'b10, {ADDI2_1, 32'h0}, 16'd2};
    vecs[4] = '{{32'h0000006F, A}, 1'b1, 2'b01, {32'h0, A},        1, 2'b00, 64'h0,            16'd0};
    vecs[5] = '{{OR9, 32'h00000073}, 1'b1, 2'b10, {OR9, 32'h0},    1, 2'b00, 64'h0,            16'd0};
    vecs[6] = '{{ADD3, ADD0},      1'b0, 2'b11, {ADD3, ADD0},      1, 2'b00, 64'h0,            16'd0};
    vecs[7] = '{{ADD6, ADDI5},     1'b0, 2'b01, {32'h0, ADDI5},    3, 2'b10, {ADD6, 32'h0},    16'd2};
    vecs[8] = '{{ADDI8, ADD7},     1'b0, 2'b11, {ADDI8, ADD7},     1, 2'b00, 64'h0,            16'd0};

    // reset held for 3 cycles
    rst = 1'b1; bndl_valid = 1'b0; flush = 1'b0; bndl_inst = '0;
    repeat (3) step();
    chk("rst_ready_low", 64'(bndl_ready), 64'h0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(bndl_ready), 64'h1);
    chk("rst_valid", 64'(iss_valid), 64'h0);
    chk("rst_stall", 64'(stall_cnt), 64'h0);
    chk("rst_inst",  iss_inst, 64'h0);

    for (int v = 0; v < 9; v++) begin
      do_reset(1);
      bndl_inst = vecs[v].inst; bndl_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", v), 64'(bndl_ready), 64'h1);
      step();
      bndl_valid = 1'b0; bndl_inst = '0;
      chk($sformatf("v%0d_illegal", v), 64'(illegal), 64'(vecs[v].ill));
      chk($sformatf("v%0d_no_early", v), 64'(iss_valid), 64'h0);
      step();
      chk($sformatf("v%0d_valid1", v), 64'(iss_valid), 64'(vecs[v].v1));
      chk($sformatf("v%0d_inst1", v), iss_inst, vecs[v].i1);
      chk($sformatf("v%0d_ill_pulse", v), 64'(illegal), 64'h0);
      repeat (vecs[v].d2) step();
      chk($sformatf("v%0d_valid2", v), 64'(iss_valid), 64'(vecs[v].v2));
      chk($sformatf("v%0d_inst2", v), iss_inst, vecs[v].i2);
      chk($sformatf("v%0d_stall", v), 64'(stall_cnt), 64'(vecs[v].stall));
    end

    // back-to-back independent bundles, no bubble
    do_reset(1);
    bndl_inst = {ADDI4, A}; bndl_valid = 1'b1;
    #1 chk("b2b_ready0", 64'(bndl_ready), 64'h1);
    step();
    bndl_inst = {OR9, XOR6};
    #1 chk("b2b_ready1", 64'(bndl_ready), 64'h1);
    step();
    chk("b2b_valid0", 64'(iss_valid), 64'h3);
    chk("b2b_inst0", iss_inst, {ADDI4, A});
    bndl_valid = 1'b0; bndl_inst = '0;
    #1 chk("b2b_ready2", 64'(bndl_ready), 64'h1);
    step();
    chk("b2b_valid1", 64'(iss_valid), 64'h3);
    chk("b2b_inst1", iss_inst, {OR9, XOR6});
    step();
    chk("b2b_idle", 64'(iss_valid), 64'h0);

    // cross-bundle RAW: A issued at "edge 10", consumer at "edge 13"
    do_reset(1);
    bndl_inst = {32'h0, A}; bndl_valid = 1'b1;
    step();
    bndl_inst = {32'h0, ADDI2_1};
    step();
    chk("raw_a_valid", 64'(iss_valid), 64'h1);
    bndl_valid = 1'b0; bndl_inst = '0;
    #1 chk("raw_ready_stalled", 64'(bndl_ready), 64'h0);
    step();
    chk("raw_e11", 64'(iss_valid), 64'h0);
    step();
    chk("raw_e12", 64'(iss_valid), 64'h0);
    step();
    chk("raw_e13_valid", 64'(iss_valid), 64'h1);
    chk("raw_e13_inst", iss_inst, {32'h0, ADDI2_1});
    chk("raw_stall", 64'(stall_cnt), 64'h2);

    // flush while B stalls on x1; scoreboard keeps A's write
    do_reset(1);
    bndl_inst = {32'h0, A}; bndl_valid = 1'b1;
    step();
    bndl_inst = {32'h0, ADDI2_1};
    step();
    bndl_valid = 1'b0; bndl_inst = '0; flush = 1'b1;
    #1 chk("flush_ready_low", 64'(bndl_ready), 64'h0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_no_issue", 64'(iss_valid), 64'h0);
    chk("flush_ready_next", 64'(bndl_ready), 64'h1);
    bndl_inst = {32'h0, ADDI3}; bndl_valid = 1'b1;
    step();
    bndl_valid = 1'b0; bndl_inst = '0;
    chk("flush_b_dropped", 64'(iss_valid), 64'h0);
    step();
    chk("flush_c_valid", 64'(iss_valid), 64'h1);
    chk("flush_c_inst", iss_inst, {32'h0, ADDI3});

    // flush on the edge a bundle would issue: nothing issues, nothing enters the scoreboard
    do_reset(1);
    bndl_inst = {32'h0, A}; bndl_valid = 1'b1;
    step();
    bndl_valid = 1'b0; bndl_inst = '0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fwin_valid", 64'(iss_valid), 64'h0);
    chk("fwin_inst", iss_inst, 64'h0);
    bndl_inst = {32'h0, ADDI2_1}; bndl_valid = 1'b1;
    step();
    bndl_valid = 1'b0; bndl_inst = '0;
    step();
    chk("fwin_consumer_free", 64'(iss_valid), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
